// File: rtl/data_gen.sv
`default_nettype none
// data_gen: Fibonacci / BCD-up / BCD-down value sequencer paced by a prog-selected slow tick.
// Define DATA_GEN_PAUSE_EN to add the PAUSE state and honour the stop input.
module data_gen #(
  parameter int unsigned BASE_DIV = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [2:0]  prog,
  input  logic [1:0]  modulo,
  output logic [15:0] data_2,
  output logic        upd,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd3;
`ifdef DATA_GEN_PAUSE_EN
  localparam logic [1:0] S_PAUSE = 2'd2;
`endif

  localparam logic [1:0] M_FIB  = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DOWN = 2'b10;
  localparam logic [1:0] M_NONE = 2'b11;

  function automatic logic [15:0] f_bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] f_bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [1:0]  r_state, w_state_d;
  logic [31:0] r_div, w_div_d;
  logic [1:0]  r_mode, w_mode_d;
  logic [15:0] r_cur, w_cur_d;
  logic [16:0] r_nxt, w_nxt_d;
  logic [15:0] r_data, w_data_d;
  logic        r_upd, w_upd_d;
  logic        r_busy, r_done;

  logic [31:0] w_thresh;
  logic        w_tick;
  logic        w_load;
  logic        w_stop;
  logic [15:0] w_inc, w_dec;

  // >= rather than == so a prog decrease mid-count ticks on the next cycle.
  assign w_thresh = (BASE_DIV << prog) - 32'd1;
  assign w_tick   = (r_state == S_RUN) && (r_div >= w_thresh);
  assign w_load   = start && (modulo != M_NONE) &&
                    ((r_state == S_IDLE) || (r_state == S_DONE));
`ifdef DATA_GEN_PAUSE_EN
  assign w_stop   = stop && (r_state == S_RUN);
`else
  assign w_stop   = 1'b0 & stop;
`endif
  assign w_inc    = f_bcd_inc(r_data);
  assign w_dec    = f_bcd_dec(r_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_load) w_state_d = S_RUN;
      S_RUN: begin
        if (w_stop) begin
`ifdef DATA_GEN_PAUSE_EN
          w_state_d = S_PAUSE;
`endif
        end else if (w_tick) begin
          case (r_mode)
            M_FIB:   if (r_nxt[16])           w_state_d = S_DONE;
            M_UP:    if (w_inc == 16'h9999)   w_state_d = S_DONE;
            M_DOWN:  if (w_dec == 16'h0000)   w_state_d = S_DONE;
            default: w_state_d = S_RUN;
          endcase
        end
      end
`ifdef DATA_GEN_PAUSE_EN
      S_PAUSE: if (start && !stop) w_state_d = S_RUN;
`endif
      default: w_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_div_d  = r_div;
    w_mode_d = r_mode;
    w_cur_d  = r_cur;
    w_nxt_d  = r_nxt;
    w_data_d = r_data;
    w_upd_d  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_load) begin
          w_mode_d = modulo;
          w_div_d  = 32'd0;
          w_cur_d  = 16'd0;
          w_nxt_d  = 17'd1;
          w_data_d = (modulo == M_DOWN) ? 16'h9999 : 16'h0000;
        end
      end
      S_RUN: begin
        if (w_stop) begin
          w_div_d = r_div;
        end else if (w_tick) begin
          w_div_d = 32'd0;
          case (r_mode)
            M_FIB: begin
              if (!r_nxt[16]) begin
                w_cur_d  = r_nxt[15:0];
                w_nxt_d  = {1'b0, r_cur} + {1'b0, r_nxt[15:0]};
                w_data_d = r_nxt[15:0];
                w_upd_d  = 1'b1;
              end
            end
            M_UP: begin
              w_data_d = w_inc;
              w_upd_d  = 1'b1;
            end
            M_DOWN: begin
              w_data_d = w_dec;
              w_upd_d  = 1'b1;
            end
            default: w_upd_d = 1'b0;
          endcase
        end else begin
          w_div_d = r_div + 32'd1;
        end
      end
      default: w_div_d = r_div;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div  <= 32'd0;
      r_mode <= M_FIB;
      r_cur  <= 16'd0;
      r_nxt  <= 17'd1;
      r_data <= 16'd0;
      r_upd  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_div  <= w_div_d;
      r_mode <= w_mode_d;
      r_cur  <= w_cur_d;
      r_nxt  <= w_nxt_d;
      r_data <= w_data_d;
      r_upd  <= w_upd_d;
      r_busy <= (w_state_d == S_RUN);
      r_done <= (w_state_d == S_DONE);
    end
  end

  assign data_2 = r_data;
  assign upd    = r_upd;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_data_gen.sv
`default_nettype none
// tb_data_gen: directed self-checking bench for data_gen (BASE_DIV=4 main, BASE_DIV=1 for full BCD runs).
module tb_data_gen;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [2:0]  prog;
  logic [1:0]  modulo;
  logic [15:0] data_2;
  logic        upd, busy, done;

  logic        f_start, f_stop;
  logic [2:0]  f_prog;
  logic [1:0]  f_modulo;
  logic [15:0] f_data;
  logic        f_upd, f_busy, f_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_gen #(.BASE_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .prog(prog), .modulo(modulo),
    .data_2(data_2), .upd(upd), .busy(busy), .done(done)
  );

  data_gen #(.BASE_DIV(1)) u_fast (
    .clk(clk), .rst(rst), .start(f_start), .stop(f_stop), .prog(f_prog), .modulo(f_modulo),
    .data_2(f_data), .upd(f_upd), .busy(f_busy), .done(f_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_upd(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (upd !== 1'b1 && cyc < max_cyc);
    check("upd_seen", 32'(upd), 32'd1);
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, cnt;
    int a, b, t;
    rst = 1'b0; start = 1'b0; stop = 1'b0; prog = 3'd0; modulo = 2'd0;
    f_start = 1'b0; f_stop = 1'b0; f_prog = 3'd0; f_modulo = 2'd0;
    repeat (2) step();
    check("rst_data", 32'(data_2), 32'h0);
    check("rst_upd",  32'(upd),    32'd0);
    check("rst_busy", 32'(busy),   32'd0);
    check("rst_done", 32'(done),   32'd0);
    rst = 1'b1;
    step();

    // modulo=11 start is ignored
    modulo = 2'b11; start = 1'b1; step(); start = 1'b0;
    check("m11_busy", 32'(busy), 32'd0);
    check("m11_data", 32'(data_2), 32'h0);
    cnt = 0;
    repeat (10) begin step(); if (upd) cnt++; end
    check("m11_upd", 32'(cnt), 32'd0);

    // Fibonacci, prog=0, modulo changed mid-run
    modulo = 2'b00; prog = 3'd0; start = 1'b1; step(); start = 1'b0;
    check("fib_busy", 32'(busy), 32'd1);
    check("fib_load", 32'(data_2), 32'h0);
    check("fib_load_upd", 32'(upd), 32'd0);
    modulo = 2'b01;
    a = 0; b = 1;
    for (int k = 1; k <= 24; k++) begin
      wait_upd(10, cyc);
      check("fib_int", 32'(cyc), 32'd4);
      check("fib_data", 32'(data_2), 32'(b));
      t = a + b; a = b; b = t;
    end
    cnt = 0;
    repeat (4) begin step(); if (upd) cnt++; end
    check("fib_end_upd",  32'(cnt),    32'd0);
    check("fib_end_done", 32'(done),   32'd1);
    check("fib_end_busy", 32'(busy),   32'd0);
    check("fib_end_data", 32'(data_2), 32'hB520);

    // BCD up, prog=2, async reset at 0012
    modulo = 2'b01; prog = 3'd2; start = 1'b1; step(); start = 1'b0;
    check("up_load", 32'(data_2), 32'h0);
    check("up_busy", 32'(busy), 32'd1);
    check("up_done", 32'(done), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      wait_upd(40, cyc);
      check("up_int", 32'(cyc), 32'd16);
      check("up_data", 32'(data_2), 32'(to_bcd(k)));
    end
    rst = 1'b0;
    #1;
    check("arst_data", 32'(data_2), 32'h0);
    check("arst_busy", 32'(busy),   32'd0);
    check("arst_done", 32'(done),   32'd0);
    check("arst_upd",  32'(upd),    32'd0);
    step();
    rst = 1'b1;
    cnt = 0;
    repeat (100) begin step(); if (upd) cnt++; end
    check("idle_upd",  32'(cnt),  32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    start = 1'b1; step(); start = 1'b0;
    check("up2_load", 32'(data_2), 32'h0);
    for (int k = 1; k <= 100; k++) begin
      wait_upd(40, cyc);
      check("up2_int", 32'(cyc), 32'd16);
      check("up2_data", 32'(data_2), 32'(to_bcd(k)));
    end

    // stop on the tick cycle
    repeat (15) step();
    stop = 1'b1; step(); stop = 1'b0;
`ifdef DATA_GEN_PAUSE_EN
    check("pause_upd",  32'(upd),    32'd0);
    check("pause_busy", 32'(busy),   32'd0);
    check("pause_data", 32'(data_2), 32'h0100);
    cnt = 0;
    repeat (50) begin step(); if (upd) cnt++; end
    check("pause_hold_upd", 32'(cnt), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    check("resume_busy", 32'(busy),   32'd1);
    check("resume_upd",  32'(upd),    32'd0);
    check("resume_data", 32'(data_2), 32'h0100);
    step();
    check("resume_step_upd",  32'(upd),    32'd1);
    check("resume_step_data", 32'(data_2), 32'h0101);
`else
    check("stop_ign_upd",  32'(upd),    32'd1);
    check("stop_ign_data", 32'(data_2), 32'h0101);
    check("stop_ign_busy", 32'(busy),   32'd1);
`endif

    // start in RUN is ignored
    start = 1'b1; step(); start = 1'b0;
    wait_upd(40, cyc);
    check("run_start_int",  32'(cyc),    32'd15);
    check("run_start_data", 32'(data_2), 32'h0102);

    // BCD down, prog=0
    rst = 1'b0; step(); rst = 1'b1; step();
    modulo = 2'b10; prog = 3'd0; start = 1'b1; step(); start = 1'b0;
    check("dn_load", 32'(data_2), 32'h9999);
    check("dn_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      wait_upd(10, cyc);
      check("dn_int", 32'(cyc), 32'd4);
      check("dn_data", 32'(data_2), 32'(to_bcd(9999 - k)));
    end

    // full BCD runs on the 1-cycle-tick instance
    f_modulo = 2'b01; f_start = 1'b1; step(); f_start = 1'b0;
    check("f_up_load", 32'(f_data), 32'h0);
    check("f_up_busy", 32'(f_busy), 32'd1);
    for (int k = 1; k <= 9999; k++) begin
      step();
      check("f_up_upd",  32'(f_upd),  32'd1);
      check("f_up_data", 32'(f_data), 32'(to_bcd(k)));
    end
    check("f_up_done", 32'(f_done), 32'd1);
    check("f_up_busy_end", 32'(f_busy), 32'd0);
    step();
    check("f_up_hold_upd",  32'(f_upd),  32'd0);
    check("f_up_hold_data", 32'(f_data), 32'h9999);
    check("f_up_hold_done", 32'(f_done), 32'd1);

    f_modulo = 2'b10; f_start = 1'b1; step(); f_start = 1'b0;
    check("f_dn_load", 32'(f_data), 32'h9999);
    check("f_dn_busy", 32'(f_busy), 32'd1);
    check("f_dn_done0", 32'(f_done), 32'd0);
    for (int k = 1; k <= 9999; k++) begin
      step();
      check("f_dn_upd",  32'(f_upd),  32'd1);
      check("f_dn_data", 32'(f_data), 32'(to_bcd(9999 - k)));
    end
    check("f_dn_done", 32'(f_done), 32'd1);
    check("f_dn_end",  32'(f_data), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
